// File: rtl/unpack_float64.sv
// -----------------------------------------------------------------------------
// unpack_float64
//
// Splits an IEEE-754 binary64 operand into sign, biased 13-bit two's-complement
// exponent and a left-aligned 64-bit significand. The significand has the
// hidden bit at zSig[62] and ten zero round bits at zSig[9:0]. This is the
// layout that round_and_pack-style packers consume.
//
// Subnormals are normalised one bit per cycle. The exponent goes to
// 1 - shift_count, so it becomes negative for small subnormals.
//
// The block is controlled with the ap_ctrl_hs handshake (ap_start / ap_done /
// ap_idle / ap_ready).
//
// Optional feature, enabled by defining the macro UNPACK_SNAN_INVALID_EN:
// a signalling NaN raises FLAG_INVALID on float_exception_flag_o. The flag is
// written through the ap_vld strobe during the DONE cycle, and the significand
// is output quieted (zSig[61] = 1). When the macro is undefined, an sNaN passes
// through with its payload unchanged and no flag is written.
//
// Ports
//   ap_clk                         clock
//   ap_rst                         asynchronous active-high reset
//   ap_start                       start request, sampled only in IDLE
//   ap_done / ap_ready             one-cycle result-valid pulse (DONE state)
//   ap_idle                        FSM in IDLE and ap_start low
//   a[63:0]                        packed binary64 operand
//   float_exception_flag_i[31:0]   incoming exception flags
//   float_exception_flag_o[31:0]   updated exception flags
//   float_exception_flag_o_ap_vld  flag write strobe
//   zSign                          sign
//   zExp[12:0]                     biased exponent, two's complement
//   zSig[63:0]                     significand, hidden bit at [62]
//   zClass[2:0]                    0 zero, 1 subnormal, 2 normal, 3 inf,
//                                  4 qNaN, 5 sNaN
// -----------------------------------------------------------------------------
module unpack_float64 #(
  parameter logic [31:0] FLAG_INVALID = 32'd16,
  parameter logic [10:0] EXP_MAX      = 11'd2047
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld,
  output logic        zSign,
  output logic [12:0] zExp,
  output logic [63:0] zSig,
  output logic [2:0]  zClass
);

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DECODE = 4'b0010,
    NORM   = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t      state;
  logic [63:0] a_reg;
  logic [52:0] sig;      // subnormal significand being shifted toward bit 52
  logic [5:0]  cnt;      // shifts applied so far, at most 52

  logic        sign_f;
  logic [10:0] exp_f;
  logic [51:0] frac_f;
  logic signed [12:0] exp_norm;
  logic        snan_hit;

  // Class of an all-ones-exponent operand. The quiet bit decides qNaN/sNaN.
  function automatic logic [2:0] special_class(input logic [51:0] f);
    if (f == '0)
      return CLS_INF;
    else if (f[51])
      return CLS_QNAN;
    else
      return CLS_SNAN;
  endfunction

  // Fraction that is forwarded for an all-ones exponent. Infinity keeps a zero
  // fraction, and a qNaN already has the quiet bit set. So forcing the quiet
  // bit only affects an sNaN.
  function automatic logic [51:0] special_frac(input logic [51:0] f);
`ifdef UNPACK_SNAN_INVALID_EN
    if (f != '0)
      return {1'b1, f[50:0]};
    else
      return f;
`else
    return f;
`endif
  endfunction

  assign sign_f = a_reg[63];
  assign exp_f  = a_reg[62:52];
  assign frac_f = a_reg[51:0];

  // A subnormal has an effective exponent of 1. Each left shift lowers it by one.
  assign exp_norm = 13'sd1 - $signed({7'b0, cnt});

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      sig    <= '0;
      cnt    <= '0;
      zSign  <= 1'b0;
      zExp   <= '0;
      zSig   <= '0;
      zClass <= CLS_ZERO;
    end else begin
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            a_reg <= a;
            state <= DECODE;
          end
        end

        // ---- decode stage: classify and finish everything except subnormals
        DECODE: begin
          if (exp_f == '0) begin
            if (frac_f == '0) begin
              zSign  <= sign_f;
              zExp   <= '0;
              zSig   <= '0;
              zClass <= CLS_ZERO;
              state  <= DONE;
            end else begin
              sig   <= {1'b0, frac_f};
              cnt   <= '0;
              state <= NORM;
            end
          end else if (exp_f == EXP_MAX) begin
            zSign  <= sign_f;
            zExp   <= {2'b00, EXP_MAX};
            zSig   <= {2'b00, special_frac(frac_f), 10'b0};
            zClass <= special_class(frac_f);
            state  <= DONE;
          end else begin
            zSign  <= sign_f;
            zExp   <= {2'b00, exp_f};
            zSig   <= {1'b0, 1'b1, frac_f, 10'b0};
            zClass <= CLS_NORM;
            state  <= DONE;
          end
        end

        // ---- normalise stage: one left shift per cycle until bit 52 is set
        NORM: begin
          if (sig[52]) begin
            zSign  <= sign_f;
            zExp   <= exp_norm;
            zSig   <= {1'b0, sig, 10'b0};
            zClass <= CLS_SUB;
            state  <= DONE;
          end else begin
            sig <= {sig[51:0], 1'b0};
            cnt <= cnt + 6'd1;
          end
        end

        // ---- done stage: result presented for exactly one cycle
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ap_done  = (state == DONE);
  assign ap_ready = ap_done;
  assign ap_idle  = (state == IDLE) && !ap_start;

`ifdef UNPACK_SNAN_INVALID_EN
  assign snan_hit = ap_done && (zClass == CLS_SNAN);
`else
  assign snan_hit = 1'b0;
`endif

  assign float_exception_flag_o        = float_exception_flag_i | (snan_hit ? FLAG_INVALID : 32'd0);
  assign float_exception_flag_o_ap_vld = snan_hit;

endmodule

// File: doc/unpack_float64.md
Name: unpack_float64

Overview:
- Unpacks an IEEE-754 binary64 operand into sign, biased 13-bit exponent and left-aligned 64-bit significand.
- Output uses the format that round_and_pack-style packers consume: hidden bit at zSig[62], round bits at [9:0].
- Subnormals are normalized iteratively, one bit per cycle, with the exponent driven negative as needed.
- Sits on the operand side of the DF MUL/ADD datapath, ahead of the core arithmetic, under the standard ap_ctrl_hs block handshake.

Parameters:
- FLAG_INVALID, 32'd16, float_exception_flag bit OR-ed in for a signaling NaN.
- EXP_MAX, 11'd2047, all-ones binary64 exponent field.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  start request, sampled only in IDLE
- ap_done  out  1  result valid (DONE state)
- ap_idle  out  1  FSM in IDLE and ap_start low
- ap_ready  out  1  equals ap_done
- a  in  64  packed binary64 operand
- float_exception_flag_i  in  32  incoming exception flags
- float_exception_flag_o  out  32  updated exception flags
- float_exception_flag_o_ap_vld  out  1  flag write strobe
- zSign  out  1  sign
- zExp  out  13  exponent, two's complement, biased
- zSig  out  64  significand, hidden bit at [62], 10 zero LSBs
- zClass  out  3  0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is asynchronous and active-high.
- Reset state: FSM=IDLE; zSign=0, zExp=0, zSig=0, zClass=0; ap_done=0, ap_ready=0, vld=0. float_exception_flag_o mirrors float_exception_flag_i.
- FSM is one-hot, 4 states:
  - IDLE: when ap_start=1, latch a into a_reg and go to DECODE. ap_start in any other state is ignored.
  - DECODE: split a_reg into s, e[10:0], f[51:0].
    - e==0, f==0: zero. zExp=0, zSig=0, go to DONE.
    - e==0, f!=0: load sig=f (53-bit), cnt=0, go to NORM.
    - 0<e<2047: zExp={2'b0,e}, zSig={1'b0,1'b1,f,10'b0}, go to DONE.
    - e==2047: zExp=13'd2047, zSig={2'b00,f,10'b0}. Class is inf if f==0, qNaN if f[51]=1, else sNaN. Go to DONE.
  - NORM: each cycle, if sig[52]=1 then zExp=13'd1-cnt (13-bit wrap), zSig={1'b0,sig,10'b0}, go to DONE. Otherwise sig<<=1, cnt+=1. cnt is 6 bits and never exceeds 52.
  - DONE: ap_done=ap_ready=1 for exactly one cycle, then IDLE.
- Latency, counting the cycle ap_start is accepted as cycle 0:
  - zero/normal/inf/NaN: DONE at cycle 2.
  - subnormal with leading one at f[k]: DONE at cycle 2+(53-k); k=51 gives cycle 4, k=0 gives cycle 55.
- Output holding: zSign/zExp/zSig/zClass update only on the DECODE/NORM cycle that moves the FSM to DONE, and hold until the next such update.
- Flags: float_exception_flag_o = float_exception_flag_i and vld=0, except as stated under Optional Feature. Subnormal inputs raise no flag.
- Reset mid-operation: returns to IDLE immediately and clears all outputs. A partial normalization is discarded.
- Back-to-back: ap_start held high across DONE starts the next operand on the IDLE cycle after DONE.

Optional Feature:
- Macro: UNPACK_SNAN_INVALID_EN.
- Defined: in DONE with zClass=5, float_exception_flag_o = float_exception_flag_i | FLAG_INVALID and float_exception_flag_o_ap_vld=1 for that cycle.
  - The quieted significand is also output: zSig[61]=1.
- Undefined: no flag write. An sNaN is passed with its payload unchanged and zClass=5.

Test Plan:
- 1.0, a=64'h3FF0000000000000 -> DONE at cycle 2; zSign=0, zExp=13'd1023, zSig=64'h4000000000000000, zClass=2, vld=0.
- Minimum subnormal, a=64'h8000000000000001 -> DONE at cycle 55; zSign=1, zExp=13'h1FCD (-51), zSig=64'h4000000000000000, zClass=1.
- Largest-leading subnormal, a=64'h0008000000000000 -> DONE at cycle 4; zExp=13'd0, zSig=64'h4000000000000000.
- sNaN, a=64'h7FF0000000000001, flags_i=32'd1:
  - Macro defined -> flags_o=32'd17, vld=1 in DONE, zClass=5, zExp=2047.
  - Macro undefined -> vld=0, zSig=64'h0000000000000400.
- +inf then -0 back-to-back with ap_start held high -> DONE pulses at cycles 2 and 5; zClass 3 then 0; zSign 0 then 1.
- Subnormal 64'h0000000000000001 with ap_rst pulsed at cycle 20 -> ap_done never asserts; outputs zero; ap_idle=1 once ap_start drops.
